// File: rtl/rdata_batcher.sv
// Groups read beats into packets of batch_len beats (tlast on the closing beat); flush or idle timeout (RDATA_BATCH_TIMEOUT_EN) closes partial batches.
// Latency 2 cycles input-to-output; s_axis_tready drops only when both hold and output registers are full and the output is stalled.
module rdata_batcher #(
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 16,
  parameter int TO_WIDTH   = 16
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  input  logic [LEN_WIDTH-1:0]    batch_len,
  input  logic [TO_WIDTH-1:0]     timeout_cycles,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [31:0]             pkt_count,
  output logic [31:0]             beat_count,
  output logic                    busy
);

  logic                  h_vld_q, h_vld_d;
  logic [DATA_WIDTH-1:0] h_dat_q;
  logic [LEN_WIDTH-1:0]  h_idx_q, h_idx_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  flush_q, flush_d;
  logic                  m_vld_q, m_vld_d;
  logic                  m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_dat_q;
  logic [31:0]           pkt_q, pkt_d;
  logic [31:0]           beat_q, beat_d;

  logic o_ready, s_hs, m_hs, flush_req, timeout_hit, close, move, new_batch;

  assign o_ready       = ~m_vld_q | m_axis_tready;
  assign s_axis_tready = axi_aresetn & (~h_vld_q | o_ready);
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign m_hs          = m_vld_q & m_axis_tready;
  assign flush_req     = flush_q | (flush & h_vld_q);
  assign close         = (h_idx_q == len_q) | flush_req | timeout_hit;
  // H only leaves without closing when a successor beat replaces it in the same cycle
  assign move          = h_vld_q & o_ready & (close | s_axis_tvalid);
  assign new_batch     = ~h_vld_q | (move & close);

`ifdef RDATA_BATCH_TIMEOUT_EN
  logic [TO_WIDTH-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (s_hs | move) begin
      idle_d = '0;
    end else if (h_vld_q & ~s_axis_tvalid & ~(&idle_q)) begin
      idle_d = idle_q + TO_WIDTH'(1);
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  assign timeout_hit = (timeout_cycles != '0) & (idle_q >= timeout_cycles);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    h_vld_d  = h_vld_q;
    h_idx_d  = h_idx_q;
    len_d    = len_q;
    flush_d  = flush_q;
    m_vld_d  = m_vld_q;
    m_last_d = m_last_q;
    pkt_d    = pkt_q;
    beat_d   = beat_q;

    if (move) begin
      h_vld_d = 1'b0;
      if (close) begin
        h_idx_d = '0;
      end
    end
    if (s_hs) begin
      h_vld_d = 1'b1;
      if (new_batch) begin
        h_idx_d = LEN_WIDTH'(1);
        len_d   = (batch_len == '0) ? LEN_WIDTH'(1) : batch_len;
      end else begin
        h_idx_d = h_idx_q + LEN_WIDTH'(1);
      end
    end

    // a flush arriving with H empty has nothing to close and is dropped
    if (move & close) begin
      flush_d = 1'b0;
    end else if (flush & h_vld_q) begin
      flush_d = 1'b1;
    end

    if (m_axis_tready) begin
      m_vld_d = 1'b0;
    end
    if (move) begin
      m_vld_d  = 1'b1;
      m_last_d = close;
    end

    if (m_hs) begin
      beat_d = beat_q + 32'd1;
      if (m_last_q) begin
        pkt_d = pkt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      h_vld_q  <= 1'b0;
      h_idx_q  <= '0;
      len_q    <= '0;
      flush_q  <= 1'b0;
      m_vld_q  <= 1'b0;
      m_last_q <= 1'b0;
      pkt_q    <= '0;
      beat_q   <= '0;
    end else begin
      h_vld_q  <= h_vld_d;
      h_idx_q  <= h_idx_d;
      len_q    <= len_d;
      flush_q  <= flush_d;
      m_vld_q  <= m_vld_d;
      m_last_q <= m_last_d;
      pkt_q    <= pkt_d;
      beat_q   <= beat_d;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (s_hs) begin
      h_dat_q <= s_axis_tdata;
    end
    if (move) begin
      m_dat_q <= h_dat_q;
    end
  end

  assign m_axis_tdata  = m_dat_q;
  assign m_axis_tkeep  = '1;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tvalid = m_vld_q;
  assign pkt_count     = pkt_q;
  assign beat_count    = beat_q;
  assign busy          = h_vld_q | m_vld_q;

endmodule

// File: tb/tb_rdata_batcher.sv
// Randomized bench for rdata_batcher: a packetizing queue model predicts every output beat and its tlast.
module tb_rdata_batcher;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int TW = 8;
  localparam int KW = DW / 8;

  logic          axi_aclk;
  logic          axi_aresetn;
  logic [LW-1:0] batch_len;
  logic [TW-1:0] timeout_cycles;
  logic          flush;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [31:0]   pkt_count;
  logic [31:0]   beat_count;
  logic          busy;

  rdata_batcher #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .TO_WIDTH(TW)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .batch_len(batch_len),
    .timeout_cycles(timeout_cycles), .flush(flush),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .pkt_count(pkt_count), .beat_count(beat_count), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int first_vld_cyc = -1;
  int mon_beats = 0;

  // model: expected output beats in order, packetized by the batch rules
  logic [DW-1:0] exp_d[$];
  bit            exp_l[$];
  int            model_cnt = 0;
  int            model_len = 1;
  int            model_pkts = 0;

  logic          hold_vld = 1'b0;
  logic [DW-1:0] hold_dat;
  logic          hold_last;

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;
  always @(posedge axi_aclk) cyc <= cyc + 1;

  function automatic void model_clear();
    exp_d.delete();
    exp_l.delete();
    model_cnt  = 0;
    model_pkts = 0;
    mon_beats  = 0;
    first_vld_cyc = -1;
  endfunction

  function automatic void model_push(input logic [DW-1:0] d);
    bit l;
    if (model_cnt == 0) model_len = (batch_len == '0) ? 1 : int'(batch_len);
    model_cnt++;
    l = (model_cnt == model_len);
    exp_d.push_back(d);
    exp_l.push_back(l);
    if (l) begin
      model_cnt = 0;
      model_pkts++;
    end
  endfunction

  function automatic void model_close();
    if (model_cnt != 0 && exp_l.size() > 0) begin
      exp_l[exp_l.size()-1] = 1'b1;
      model_cnt = 0;
      model_pkts++;
    end
  endfunction

  always @(negedge axi_aclk) begin
    if (!axi_aresetn) begin
      hold_vld = 1'b0;
    end else begin
      if (m_axis_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (hold_vld && m_axis_tvalid) begin
        checks++;
        if (m_axis_tdata !== hold_dat || m_axis_tlast !== hold_last) begin
          errors++;
          $display("FAIL stall_stable: got %h/%b want %h/%b", m_axis_tdata, m_axis_tlast, hold_dat, hold_last);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL out_beat: got unexpected beat %h last %b", m_axis_tdata, m_axis_tlast);
        end else begin
          logic [DW-1:0] ed;
          bit el;
          ed = exp_d.pop_front();
          el = exp_l.pop_front();
          if (m_axis_tdata !== ed || m_axis_tlast !== el || m_axis_tkeep !== {KW{1'b1}}) begin
            errors++;
            $display("FAIL out_beat: got %h last %b keep %h want %h last %b keep all-ones",
                     m_axis_tdata, m_axis_tlast, m_axis_tkeep, ed, el);
          end
        end
        mon_beats++;
        hold_vld = 1'b0;
      end else if (m_axis_tvalid) begin
        hold_vld  = 1'b1;
        hold_dat  = m_axis_tdata;
        hold_last = m_axis_tlast;
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    flush = 1'b0;
    m_axis_tready = 1'b1;
    timeout_cycles = '0;
    @(posedge axi_aclk); #2;
    axi_aresetn = 1'b0;
    model_clear();
    repeat (2) @(posedge axi_aclk);
    #2 axi_aresetn = 1'b1;
    @(posedge axi_aclk); #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int t;
    t = 0;
    s_axis_tdata = d;
    s_axis_tvalid = 1'b1;
    @(negedge axi_aclk);
    while (s_axis_tready !== 1'b1 && t < 300) begin
      @(negedge axi_aclk);
      t++;
    end
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL send_accept: tready %b after %0d cycles, want 1", s_axis_tready, t);
    end else begin
      model_push(d);
      last_hs_cyc = cyc;
    end
    @(posedge axi_aclk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    model_close();
    @(posedge axi_aclk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int budget);
    int t;
    t = 0;
    while (mon_beats < target && t < budget) begin
      @(negedge axi_aclk);
      t++;
    end
    @(posedge axi_aclk); #1;
  endtask

  task automatic test_reset();
    axi_aresetn = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    flush = 1'b0;
    m_axis_tready = 1'b1;
    batch_len = 8'd1;
    timeout_cycles = '0;
    #2 axi_aresetn = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b want 0", m_axis_tlast); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (pkt_count !== 32'd0 || beat_count !== 32'd0) begin errors++; $display("FAIL rst_counts: got %0d/%0d want 0/0", pkt_count, beat_count); end
    model_clear();
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'hA5A5_0001;
    repeat (2) @(posedge axi_aclk);
    #1;
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", s_axis_tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_no_accept: busy %b want 0", busy); end
    #2 axi_aresetn = 1'b1;
    model_push(s_axis_tdata);
    @(posedge axi_aclk); #1;
    s_axis_tvalid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_edge_accept: busy %b want 1", busy); end
    wait_beats(1, 10);
    checks++; if (pkt_count !== 32'd1 || beat_count !== 32'd1) begin errors++; $display("FAIL first_beat_counts: got %0d/%0d want 1/1", pkt_count, beat_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    batch_len = 8'd4;
    for (int i = 0; i < 8; i++) send_beat($urandom);
    wait_beats(8, 50);
    checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL b2b_pkts: got %0d want 2", pkt_count); end
    checks++; if (beat_count !== 32'd8) begin errors++; $display("FAIL b2b_beats: got %0d want 8", beat_count); end
    checks++; if (busy !== 1'b0 || exp_d.size() != 0) begin errors++; $display("FAIL b2b_drain: busy %b pending %0d want 0/0", busy, exp_d.size()); end
  endtask

  task automatic test_len0();
    int hs0;
    do_reset();
    batch_len = 8'd0;
    send_beat($urandom);
    hs0 = last_hs_cyc;
    send_beat($urandom);
    send_beat($urandom);
    wait_beats(3, 50);
    checks++; if (first_vld_cyc - hs0 != 2) begin errors++; $display("FAIL len0_latency: got %0d want 2", first_vld_cyc - hs0); end
    checks++; if (pkt_count !== 32'd3 || beat_count !== 32'd3) begin errors++; $display("FAIL len0_counts: got %0d/%0d want 3/3", pkt_count, beat_count); end
  endtask

  task automatic test_timeout();
    int hs3;
    do_reset();
    batch_len = 8'd8;
    timeout_cycles = 8'd10;
    for (int i = 0; i < 3; i++) send_beat($urandom);
    hs3 = last_hs_cyc;
`ifdef RDATA_BATCH_TIMEOUT_EN
    begin
      int t;
      int gap;
      model_close();
      t = 0;
      @(negedge axi_aclk);
      while (!(m_axis_tvalid === 1'b1 && m_axis_tlast === 1'b1) && t < 60) begin
        @(negedge axi_aclk);
        t++;
      end
      gap = cyc - hs3;
      checks++;
      if (!(m_axis_tvalid === 1'b1 && m_axis_tlast === 1'b1) || gap < 11 || gap > 13) begin
        errors++;
        $display("FAIL timeout_flush: tvalid %b tlast %b gap %0d want 1/1 gap 11..13", m_axis_tvalid, m_axis_tlast, gap);
      end
      wait_beats(3, 20);
      checks++; if (pkt_count !== 32'd1 || beat_count !== 32'd3) begin errors++; $display("FAIL timeout_counts: got %0d/%0d want 1/3", pkt_count, beat_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", busy); end
    end
`else
    repeat (40) @(negedge axi_aclk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL no_timeout_busy: got %b want 1 (hs at %0d)", busy, hs3); end
    checks++; if (pkt_count !== 32'd0 || beat_count !== 32'd2) begin errors++; $display("FAIL no_timeout_counts: got %0d/%0d want 0/2", pkt_count, beat_count); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL no_timeout_tvalid: got %b want 0", m_axis_tvalid); end
`endif
    timeout_cycles = '0;
  endtask

  task automatic test_flush();
    do_reset();
    batch_len = 8'd4;
    send_beat($urandom);
    send_beat($urandom);
    pulse_flush();
    for (int i = 0; i < 4; i++) send_beat($urandom);
    wait_beats(6, 50);
    checks++; if (pkt_count !== 32'd2 || beat_count !== 32'd6) begin errors++; $display("FAIL flush_counts: got %0d/%0d want 2/6", pkt_count, beat_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle: busy %b want 0", busy); end
    pulse_flush();
    send_beat($urandom);
    send_beat($urandom);
    repeat (5) @(posedge axi_aclk);
    #1;
    checks++; if (pkt_count !== 32'd2 || beat_count !== 32'd7 || busy !== 1'b1) begin
      errors++; $display("FAIL flush_dropped: got %0d/%0d busy %b want 2/7 busy 1", pkt_count, beat_count, busy);
    end
    pulse_flush();
    wait_beats(8, 30);
    checks++; if (pkt_count !== 32'd3 || beat_count !== 32'd8) begin errors++; $display("FAIL flush_final: got %0d/%0d want 3/8", pkt_count, beat_count); end
  endtask

  task automatic test_stall();
    do_reset();
    batch_len = 8'd2;
    m_axis_tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_beat($urandom);
      end
      begin
        repeat (20) @(negedge axi_aclk);
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL stall_tready: got %b want 0", s_axis_tready); end
        checks++; if (exp_d.size() != 2) begin errors++; $display("FAIL stall_accepted: got %0d want 2", exp_d.size()); end
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d[0]) begin
          errors++; $display("FAIL stall_head: got %b/%h want 1/%h", m_axis_tvalid, m_axis_tdata, exp_d[0]);
        end
        @(posedge axi_aclk); #1;
        m_axis_tready = 1'b1;
      end
    join
    wait_beats(4, 60);
    checks++; if (pkt_count !== 32'd2 || beat_count !== 32'd4) begin errors++; $display("FAIL stall_counts: got %0d/%0d want 2/4", pkt_count, beat_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_open: busy %b want 1", busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    batch_len = 8'd4;
    m_axis_tready = 1'b0;
    send_beat($urandom);
    send_beat($urandom);
    checks++; if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre: tvalid %b busy %b want 1/1", m_axis_tvalid, busy); end
    #2 axi_aresetn = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || s_axis_tready !== 1'b0) begin
      errors++; $display("FAIL mid_async: tvalid %b busy %b tready %b want 0/0/0", m_axis_tvalid, busy, s_axis_tready);
    end
    model_clear();
    repeat (2) @(posedge axi_aclk);
    #2 axi_aresetn = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge axi_aclk); #1;
    for (int i = 0; i < 4; i++) send_beat($urandom);
    wait_beats(4, 40);
    checks++; if (pkt_count !== 32'd1 || beat_count !== 32'd4) begin errors++; $display("FAIL mid_after: got %0d/%0d want 1/4", pkt_count, beat_count); end
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    do_reset();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int g;
          batch_len = LW'($urandom_range(0, 4));
          send_beat($urandom);
          g = $urandom_range(0, 2);
          if (g > 0) begin
            repeat (g) @(posedge axi_aclk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge axi_aclk); #1;
          m_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_axis_tready = 1'b1;
    pulse_flush();
    wait_beats(40, 400);
    checks++; if (beat_count !== 32'd40) begin errors++; $display("FAIL rand_beats: got %0d want 40", beat_count); end
    checks++; if (pkt_count !== 32'(model_pkts)) begin errors++; $display("FAIL rand_pkts: got %0d want %0d", pkt_count, model_pkts); end
    checks++; if (busy !== 1'b0 || exp_d.size() != 0) begin errors++; $display("FAIL rand_drain: busy %b pending %0d want 0/0", busy, exp_d.size()); end
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_len0();
    test_timeout();
    test_flush();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rdata_batcher.md
RDATA_BATCHER -- requirements
Module: rdata_batcher

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 512, read-beat width in bits (multiple of 8).
REQ-002 SHALL have parameter LEN_WIDTH, 16, width of batch_len and the in-batch beat counter.
REQ-003 SHALL have parameter TO_WIDTH, 16, width of timeout_cycles and the idle counter.
REQ-004 SHALL have port axi_aclk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port axi_aresetn  in  1  asynchronous assert, active-low reset.
REQ-006 SHALL have port batch_len  in  LEN_WIDTH  beats per packet; 0 is treated as 1.
REQ-007 SHALL have port timeout_cycles  in  TO_WIDTH  idle cycles before a partial-batch flush; 0 disables.
REQ-008 SHALL have port flush  in  1  one-cycle request to close the open batch.
REQ-009 SHALL have ports s_axis_tdata/tvalid/tready  in/in/out  DATA_WIDTH/1/1  read-beat input, one beat per handshake.
REQ-010 SHALL have ports m_axis_tdata/tkeep/tlast/tvalid/tready  out/out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1/1  batched output.
REQ-011 SHALL have port pkt_count  out  32  packets emitted (tlast handshakes).
REQ-012 SHALL have port beat_count  out  32  beats emitted.
REQ-013 SHALL have port busy  out  1  high while any beat is held or an open batch exists.

Function
REQ-014 SHALL hold the most recent input beat in a hold register H plus its index h_idx within the batch, so tlast is decided before the beat leaves.
REQ-015 SHALL register output in O; o_ready = ~m_axis_tvalid | m_axis_tready; s_axis_tready = ~H_valid | o_ready, independent of s_axis_tvalid.
REQ-016 SHALL latch L = max(batch_len,1) when a beat enters with the batch empty; batch_len changes mid-batch SHALL NOT affect the open batch.
REQ-017 SHALL move H to O when H_valid & o_ready & (h_idx == L | s_axis_tvalid | flush_req | timeout_hit), with tlast = (h_idx == L) | flush_req | timeout_hit.
REQ-018 SHALL, on a move with tlast=1, reset the batch index so the simultaneously accepted beat (if any) becomes index 1 of a new batch.
REQ-019 SHALL drive m_axis_tkeep all-ones and never alter tdata.
REQ-020 SHALL give minimum latency 2 cycles from input handshake to m_axis_tvalid when L=1 and output not stalled.
REQ-021 SHALL hold m_axis_tdata/tlast stable while m_axis_tvalid & ~m_axis_tready.
REQ-022 SHALL make flush sticky (flush_req) until H leaves with tlast=1; flush with H empty SHALL be dropped (batch already closed).
REQ-023 SHALL count idle cycles while H_valid & ~s_axis_tvalid; counter clears on any input handshake or H move; timeout_hit = counter >= timeout_cycles & timeout_cycles != 0.
REQ-024 SHALL increment pkt_count on m handshake with tlast and beat_count on every m handshake, both wrapping 2^32-1 -> 0.
REQ-025 SHALL keep invariant: H empty implies open-batch index 0; busy = H_valid | m_axis_tvalid.

Reset
REQ-026 SHALL, on axi_aresetn low, immediately clear H_valid, m_axis_tvalid, m_axis_tlast, flush_req, batch index, idle counter, pkt_count, beat_count, busy to 0.
REQ-027 SHALL force s_axis_tready to 0 while axi_aresetn is low; beats in flight are discarded, no partial packet resumes after reset.
REQ-028 SHALL accept first beat on the first rising edge after axi_aresetn deasserts.

Configuration
REQ-029 SHALL compile idle timeout only when RDATA_BATCH_TIMEOUT_EN is defined; otherwise timeout_hit is constant 0, idle counter absent, timeout_cycles ignored, and partial batches close only via flush or reaching L.

Verification
REQ-030 SHALL verify batch_len=4, 8 back-to-back beats, tready=1 -> two packets, tlast on beats 4 and 8, pkt_count=2, beat_count=8.
REQ-031 SHALL verify batch_len=0, 3 beats -> every beat has tlast=1, pkt_count=3, first tvalid 2 cycles after first handshake.
REQ-032 SHALL verify timeout_cycles=10, batch_len=8, 3 beats then idle -> beat 3 emitted with tlast=1 after 10 idle cycles; without RDATA_BATCH_TIMEOUT_EN beat 3 stays held, busy=1.
REQ-033 SHALL verify batch_len=4, 2 beats, flush pulse -> beat 2 tlast=1; next 4 beats form a fresh packet with tlast on 4th.
REQ-034 SHALL verify m_axis_tready low 20 cycles with batch_len=2 and 5 beats offered -> s_axis_tready low after H and O fill, no data lost/reordered, tlast on beats 2 and 4.
REQ-035 SHALL verify axi_aresetn pulsed low mid-batch (2 of 4 beats) -> outputs 0 asynchronously; after release 4 new beats give one packet, pkt_count=1.
